// File: rtl/chess_cursor_ctrl.sv
// Board cursor, piece select FSM and move request producer for the painter.
// Define CHESS_CURSOR_WRAP_EN to make cursor motion wrap instead of saturate.
module chess_cursor_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [5:0]  RESET_SQ        = 6'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_center,
  input  logic [255:0] board,
  input  logic         turn,
  input  logic         move_ready,
  output logic         move_valid,
  output logic [5:0]   move_from,
  output logic [5:0]   move_to,
  output logic [12:0]  moveData
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    BROWSE,
    SELECTED,
    REQUEST
  } state_t;

  // bit order: {center, up, down, left, right}
  logic [4:0] raw;
  logic [4:0] s1;
  logic [4:0] s2;
  logic [4:0] db;
  logic [4:0] press;

  assign raw = {btn_center, btn_up, btn_down,
                btn_left, btn_right};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          hit;

    assign hit      = (s2[i] != db[i]) && (cnt == CMAX);
    assign press[i] = hit && s2[i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        db[i] <= 1'b0;
      end else if (s2[i] == db[i]) begin
        cnt <= '0;
      end else if (hit) begin
        cnt   <= '0;
        db[i] <= s2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  state_t     state;
  state_t     state_n;
  logic [5:0] cursor;
  logic [5:0] cursor_n;
  logic [5:0] sel_sq;
  logic [5:0] sel_sq_n;
  logic       sel_act;
  logic       sel_act_n;
  logic       valid_n;
  logic [5:0] from_n;
  logic [5:0] to_n;

  logic       go_l;
  logic       go_r;
  logic       go_u;
  logic       go_d;
  logic [2:0] lt;
  logic [2:0] nm;
  logic [2:0] lt_n;
  logic [2:0] nm_n;
  logic [3:0] piece;
  logic       own;

  assign go_r = press[0] & ~press[1];
  assign go_l = press[1] & ~press[0];
  assign go_d = press[2] & ~press[3];
  assign go_u = press[3] & ~press[2];

  assign lt = cursor[5:3];
  assign nm = cursor[2:0];

  assign piece = board[{cursor, 2'b00} +: 4];
  assign own   = (piece[2:0] != 3'd0) && (piece[3] == turn);

`ifdef CHESS_CURSOR_WRAP_EN
  always_comb begin
    lt_n = lt;
    nm_n = nm;
    if (go_r) lt_n = lt + 3'd1;
    if (go_l) lt_n = lt - 3'd1;
    if (go_d) nm_n = nm + 3'd1;
    if (go_u) nm_n = nm - 3'd1;
  end
`else
  always_comb begin
    lt_n = lt;
    nm_n = nm;
    if (go_r && lt != 3'd7) lt_n = lt + 3'd1;
    if (go_l && lt != 3'd0) lt_n = lt - 3'd1;
    if (go_d && nm != 3'd7) nm_n = nm + 3'd1;
    if (go_u && nm != 3'd0) nm_n = nm - 3'd1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BROWSE;
      cursor     <= RESET_SQ;
      sel_sq     <= '0;
      sel_act    <= 1'b0;
      move_valid <= 1'b0;
      move_from  <= '0;
      move_to    <= '0;
    end else begin
      state      <= state_n;
      cursor     <= cursor_n;
      sel_sq     <= sel_sq_n;
      sel_act    <= sel_act_n;
      move_valid <= valid_n;
      move_from  <= from_n;
      move_to    <= to_n;
    end
  end

  // center outranks arrows; REQUEST only listens to the handshake
  always_comb begin
    state_n   = state;
    cursor_n  = cursor;
    sel_sq_n  = sel_sq;
    sel_act_n = sel_act;
    valid_n   = move_valid;
    from_n    = move_from;
    to_n      = move_to;
    unique case (1'b1)
      state == BROWSE: begin
        if (press[4]) begin
          if (own) begin
            sel_sq_n  = cursor;
            sel_act_n = 1'b1;
            state_n   = SELECTED;
          end
        end else begin
          cursor_n = {lt_n, nm_n};
        end
      end
      state == SELECTED: begin
        if (press[4]) begin
          if (cursor == sel_sq) begin
            sel_act_n = 1'b0;
            state_n   = BROWSE;
          end else if (own) begin
            sel_sq_n = cursor;
          end else begin
            from_n  = sel_sq;
            to_n    = cursor;
            valid_n = 1'b1;
            state_n = REQUEST;
          end
        end else begin
          cursor_n = {lt_n, nm_n};
        end
      end
      state == REQUEST: begin
        if (move_valid && move_ready) begin
          valid_n   = 1'b0;
          sel_act_n = 1'b0;
          state_n   = BROWSE;
        end
      end
      default: begin
        state_n = BROWSE;
      end
    endcase
  end

  assign moveData = {sel_act, sel_sq, cursor};

endmodule

// File: tb/tb_chess_cursor_ctrl.sv
// Directed bench for chess_cursor_ctrl with a short debounce window.
// Expected cursor values follow CHESS_CURSOR_WRAP_EN when defined.
module tb_chess_cursor_ctrl;

  logic         clk;
  logic         reset;
  logic         btn_up;
  logic         btn_down;
  logic         btn_left;
  logic         btn_right;
  logic         btn_center;
  logic [255:0] board;
  logic         turn;
  logic         move_ready;
  logic         move_valid;
  logic [5:0]   move_from;
  logic [5:0]   move_to;
  logic [12:0]  moveData;

  int checks;
  int errors;

  localparam logic [4:0] C = 5'b10000;
  localparam logic [4:0] U = 5'b01000;
  localparam logic [4:0] D = 5'b00100;
  localparam logic [4:0] L = 5'b00010;
  localparam logic [4:0] R = 5'b00001;

  chess_cursor_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_SQ(6'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_center (btn_center),
    .board      (board),
    .turn       (turn),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_from  (move_from),
    .move_to    (move_to),
    .moveData   (moveData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] m);
    {btn_center, btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  task automatic hold(input logic [4:0] m, input int n);
    @(negedge clk);
    drive(m);
    repeat (n) @(negedge clk);
    drive(5'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] m);
    hold(m, 10);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    turn       = 1'b0;
    move_ready = 1'b0;
    drive(5'b0);
    board = '0;
    board[12*4 +: 4] = 4'b0110;
    board[11*4 +: 4] = 4'b1101;
    repeat (3) @(negedge clk);
    check("rst_md", 32'(moveData), 32'h0);
    check("rst_valid", 32'(move_valid), 32'h0);
    check("rst_from_to", 32'({move_from, move_to}), 32'h0);
    reset = 1'b0;

    // held right: one step only
    @(negedge clk);
    drive(R);
    repeat (10) @(negedge clk);
    check("hold_right", 32'(moveData), 32'o10);
    drive(5'b0);
    repeat (10) @(negedge clk);
    check("release", 32'(moveData), 32'o10);
    hold(R, 2);
    check("glitch", 32'(moveData), 32'o10);

    repeat (6) press(R);
    check("edge_70", 32'(moveData[5:0]), 32'o70);
    press(R);
`ifdef CHESS_CURSOR_WRAP_EN
    check("edge_right", 32'(moveData[5:0]), 32'o00);
`else
    check("edge_right", 32'(moveData[5:0]), 32'o70);
`endif
    press(U);
`ifdef CHESS_CURSOR_WRAP_EN
    check("edge_up", 32'(moveData[5:0]), 32'o07);
`else
    check("edge_up", 32'(moveData[5:0]), 32'o70);
`endif

    do_reset();
    check("rst2_md", 32'(moveData), 32'h0);
    press(R);
    press(C);
    check("ctr_empty", 32'(moveData), 32'o10);
    repeat (3) press(D);
    press(C);
    check("ctr_black", 32'(moveData), 32'o13);
    press(D);
    press(C);
    check("select", 32'(moveData), {19'd0, 1'b1, 6'o14, 6'o14});
    press(C);
    check("deselect", 32'(moveData), {19'd0, 1'b0, 6'o14, 6'o14});

    press(C);
    press(D);
    press(C);
    check("req_valid", 32'(move_valid), 32'h1);
    check("req_from", 32'(move_from), 32'o14);
    check("req_to", 32'(move_to), 32'o15);
    press(L);
    press(U);
    press(C);
    check("frz_md", 32'(moveData), {19'd0, 1'b1, 6'o14, 6'o15});
    check("frz_valid", 32'(move_valid), 32'h1);
    check("frz_ft", 32'({move_from, move_to}), 32'o1415);

    @(negedge clk);
    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b0;
    check("hs_valid", 32'(move_valid), 32'h0);
    check("hs_md", 32'(moveData), {19'd0, 1'b0, 6'o14, 6'o15});

    // center and up together: center wins, empty square
    press(C | U);
    check("ctr_up", 32'(moveData), {19'd0, 1'b0, 6'o14, 6'o15});

    press(U);
    press(C);
    press(D);
    press(C);
    check("req2_valid", 32'(move_valid), 32'h1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_valid", 32'(move_valid), 32'h0);
    check("async_md", 32'(moveData), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    press(R);
    repeat (4) press(D);
    press(C);
    check("post_rst_sel", 32'(moveData), {19'd0, 1'b1, 6'o14, 6'o14});
    check("post_rst_valid", 32'(move_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chess_cursor_ctrl.md
Name: chess_cursor_ctrl

Overview:
Input-side producer of the 13-bit `moveData` bus consumed by the VGA board painter.
- Debounces five push-buttons and moves an 8x8 board cursor.
- Runs the piece select/deselect state machine.
- Hands completed (from, to) move requests to game logic over a valid/ready handshake.
- Sits between the board buttons and the game-rules block. Reads the same 256-bit `board` vector the painter reads.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized-level cycles required to accept a button change (10 ms at 25 MHz).
- RESET_SQ, 6'd0: cursor square `{let,num}` loaded at reset.

Ports:
- clk  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- btn_up  in  1  raw button, asynchronous to clk.
- btn_down  in  1  raw button, asynchronous to clk.
- btn_left  in  1  raw button, asynchronous to clk.
- btn_right  in  1  raw button, asynchronous to clk.
- btn_center  in  1  raw button, asynchronous to clk.
- board  in  256  square i is `board[4i+3:4i]`; bit 3 is colour (0 white, 1 black); bits [2:0] are piece type (0 = empty); i = `{let[2:0],num[2:0]}`.
- turn  in  1  side to move (0 white, 1 black).
- move_ready  in  1  game logic accepts the request.
- move_valid  out  1  move request pending.
- move_from  out  6  source square `{let,num}`.
- move_to  out  6  destination square `{let,num}`.
- moveData  out  13  [5:0] cursor square, [11:6] selected square, [12] selection active.

Behaviour:
- Reset (async, active-high) forces:
  - cursor = RESET_SQ, sel_sq = 0, moveData[12] = 0
  - move_valid = 0, move_from = 0, move_to = 0
  - FSM = BROWSE
  - all sync flops, debounce counters and debounced levels = 0
- Reset mid-request drops the request; no handshake completes.
- Button path, per button:
  - 2-FF synchronizer, then debounce counter. The counter clears whenever the synced level equals the debounced level. When it reaches DEBOUNCE_CYCLES-1 with levels differing, the debounced level flips and the counter clears.
  - A one-cycle press pulse fires on the debounced rising edge only. Release generates nothing.
- Pulse-to-output latency: a pulse in cycle N updates the registered outputs at the end of cycle N (visible in N+1).
- Same-cycle pulses:
  - center has priority; if center pulses, directional pulses in that cycle are discarded.
  - up+down together gives no num change; left+right together gives no let change; one vertical and one horizontal both apply.
- Cursor motion:
  - left/right: let -/+ 1.
  - up/down: num -/+ 1 (num 0 = top row).
  - Saturates at 0 and 7 (see optional feature).
  - The cursor is frozen in state REQUEST.
- FSM states: BROWSE, SELECTED, REQUEST.
- BROWSE, on center:
  - If `board[cursor]` is non-empty and its colour == turn: sel_sq = cursor, moveData[12] = 1, go to SELECTED.
  - Otherwise no change.
- SELECTED, on center:
  - cursor == sel_sq: moveData[12] = 0, go to BROWSE.
  - Cursor holds a non-empty piece of colour == turn: sel_sq = cursor (reselect), stay in SELECTED.
  - Otherwise: move_from = sel_sq, move_to = cursor, move_valid = 1, go to REQUEST.
- REQUEST:
  - move_valid, move_from and move_to are held stable; moveData[12] stays 1.
  - All button pulses are ignored.
- Handshake: a transfer occurs on a cycle with move_valid && move_ready. Next cycle: move_valid = 0, moveData[12] = 0, FSM = BROWSE; the cursor stays at move_to.
- move_ready while move_valid = 0 is ignored.
- `turn` and `board` are sampled only on the center-pulse cycle; changes while SELECTED do not auto-deselect.
- moveData[11:6] holds the last sel_sq even when bit 12 = 0.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- CHESS_CURSOR_WRAP_EN defined: cursor motion wraps modulo 8 per axis (let 7 + right gives 0; num 0 + up gives 7).
- Undefined: motion saturates at 0 and 7.
- Priority, freeze and handshake rules are unchanged either way.

Test Plan:
- DEBOUNCE_CYCLES=4. btn_right held 10 cycles from reset → exactly one pulse; moveData[5:0] goes 0→8 (let=1) once; release produces no change. A 2-cycle glitch produces no change.
- Cursor at `{7,0}`, press right, then up → moveData[5:0] stays 6'o70 (saturating). With CHESS_CURSOR_WRAP_EN the results are 6'o00, then 6'o07.
- turn=0, board[12]=4'b0110 (white pawn at `{1,4}`), cursor 12, center → moveData[12]=1, [11:6]=12. Center again at 12 → moveData[12]=0, FSM BROWSE.
- Select 12, move cursor to 13, center → move_valid=1, move_from=12, move_to=13. Hold move_ready=0 for 5 cycles with arrow presses → outputs unchanged. move_ready=1 for 1 cycle → next cycle move_valid=0, moveData[12]=0, cursor=13.
- turn=0, center on empty square and on a black piece (4'b1101) → no selection. Center and up pulses in the same cycle → only center acts.
- Assert reset asynchronously mid-REQUEST (between clk edges) → move_valid, moveData[12] go 0 immediately; moveData[5:0]=RESET_SQ. After release, FSM is in BROWSE.
